// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: keyboard line inputs and decoded scan-code outputs of ps2_scan_rx.
// PS2_EXT_FLAG_EN adds the ext_code output.
interface ps2_scan_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scan_code;
   logic       code_valid;
   logic       frame_err;
`ifdef PS2_EXT_FLAG_EN
   logic       ext_code;
   modport master (output ps2_clk, ps2_data, input scan_code, code_valid, frame_err, ext_code);
   modport slave (input ps2_clk, ps2_data, output scan_code, code_valid, frame_err, ext_code);
`else
   modport master (output ps2_clk, ps2_data, input scan_code, code_valid, frame_err);
   modport slave (input ps2_clk, ps2_data, output scan_code, code_valid, frame_err);
`endif
endinterface

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver yielding make codes, dropping break sequences.
// Optional macro PS2_EXT_FLAG_EN adds ext_code, the E0-prefix flag registered with scan_code.
module ps2_scan_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic         clk,
   input logic         rst,
   ps2_scan_rx_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t        state, state_n;
   logic [1:0]    cs, ds;
   logic          fclk, fall, d;
   logic [FW-1:0] fcnt;
   logic [2:0]    cnt, cnt_n;
   logic [7:0]    sh, sh_n, sc;
   logic          par, par_n, brk, brk_n, ext, ext_n, cv, cv_n, fe, fe_n;
   logic [TW-1:0] tcnt, tcnt_n;
   assign d    = ds[1];
   // the falling edge is flagged in the same cycle the filter commits it
   assign fall = fclk & ~cs[1] & (fcnt == FW'(FILTER_LEN - 1));
   assign bus.scan_code  = sc;
   assign bus.code_valid = cv;
   assign bus.frame_err  = fe;
   always_ff @(posedge clk) begin
      if (rst) begin
         cs   <= 2'b11;
         ds   <= 2'b11;
         fclk <= 1'b1;
         fcnt <= '0;
      end else begin
         cs <= {cs[0], bus.ps2_clk};
         ds <= {ds[0], bus.ps2_data};
         if (cs[1] == fclk) fcnt <= '0;
         else if (fcnt == FW'(FILTER_LEN - 1)) begin
            fclk <= cs[1];
            fcnt <= '0;
         end else fcnt <= fcnt + 1'b1;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      par_n   = par;
      brk_n   = brk;
      ext_n   = ext;
      cv_n    = 1'b0;
      fe_n    = 1'b0;
      tcnt_n  = (state == IDLE) ? '0 : tcnt + 1'b1;
      if (fall) begin
         tcnt_n = '0;
         case (state)
            IDLE: begin
               state_n = d ? IDLE : DATA;
               cnt_n   = '0;
            end
            DATA: begin
               sh_n[cnt] = d;
               cnt_n     = cnt + 3'd1;
               state_n   = (cnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_n   = d;
               state_n = STOP;
            end
            default: begin
               state_n = IDLE;
               if (!(d & (^{sh, par}))) begin
                  fe_n  = 1'b1;
                  brk_n = 1'b0;
                  ext_n = 1'b0;
               end else if (sh == 8'hF0) brk_n = 1'b1;
               else if (sh == 8'hE0) ext_n = 1'b1;
               else if (brk) begin
                  brk_n = 1'b0;
                  ext_n = 1'b0;
               end else begin
                  cv_n  = 1'b1;
                  ext_n = 1'b0;
               end
            end
         endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n = IDLE;
         fe_n    = 1'b1;
         brk_n   = 1'b0;
         ext_n   = 1'b0;
         cnt_n   = '0;
         sh_n    = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sh    <= '0;
         par   <= 1'b0;
         brk   <= 1'b0;
         ext   <= 1'b0;
         tcnt  <= '0;
         sc    <= 8'h00;
         cv    <= 1'b0;
         fe    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sh    <= sh_n;
         par   <= par_n;
         brk   <= brk_n;
         ext   <= ext_n;
         tcnt  <= tcnt_n;
         sc    <= cv_n ? sh : sc;
         cv    <= cv_n;
         fe    <= fe_n;
      end
   end
`ifdef PS2_EXT_FLAG_EN
   logic ec;
   assign bus.ext_code = ec;
   always_ff @(posedge clk) begin
      if (rst) ec <= 1'b0;
      else if (cv_n) ec <= ext;
   end
`endif
endmodule
